instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 176 +++++++++++++++++
 tb/tb_instruction_encoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Instruction encoder: packs ALU/immediate or PC-relative branch requests into 32-bit words,
// tags each word with its byte address and an encoding error code, and emits it via a valid/ready handshake.
module instruction_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_load,
    input  logic [31:0] pc_load_value,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_fmt,
    input  logic [4:0]  in_opcode,
    input  logic        in_ibit,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_rs1,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [1:0]  err_code,
    output logic [15:0] count
);

    typedef enum logic [1:0] {IDLE, ENCODE, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic        fmt_q, fmt_d;
    logic [4:0]  opcode_q, opcode_d;
    logic        ibit_q, ibit_d;
    logic [3:0]  rd_q, rd_d;
    logic [3:0]  rs1_q, rs1_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] target_q, target_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instruction_q, out_instruction_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic        out_err_q, out_err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic [31:0]        off;
    logic signed [31:0] w;
    logic [31:0]        enc_word;
    logic [1:0]         enc_code;

    assign in_ready        = (state_q == IDLE) && !pc_load && !reset;
    assign out_valid       = out_valid_q;
    assign out_instruction = out_instruction_q;
    assign out_addr        = out_addr_q;
    assign out_err         = out_err_q;
    assign err_code        = err_code_q;
    assign count           = count_q;

    // Encoding works on the captured request and the current address counter.
    always_comb begin
        off      = target_q - addr_q;
        w        = $signed(off) >>> 2;
        enc_word = '0;
        enc_code = 2'b00;
        if (fmt_q) begin
            enc_word = {opcode_q, w[26:0]};
            if (target_q[1:0] != 2'b00) begin
                enc_code = 2'b10;
            end else if ((w[31:26] != '0) && (w[31:26] != '1)) begin
                enc_code = 2'b11;
            end
        end else begin
            enc_word[31:27] = opcode_q;
            enc_word[26]    = ibit_q;
            enc_word[25:22] = rd_q;
            enc_word[21:18] = rs1_q;
            if (ibit_q) begin
                enc_word[17:0] = imm_q[17:0];
                if ((imm_q[31:17] != '0) && (imm_q[31:17] != '1)) begin
                    enc_code = 2'b01;
                end
            end else begin
                enc_word[17:14] = imm_q[3:0];
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        count_d           = count_q;
        fmt_d             = fmt_q;
        opcode_d          = opcode_q;
        ibit_d            = ibit_q;
        rd_d              = rd_q;
        rs1_d             = rs1_q;
        imm_d             = imm_q;
        target_d          = target_q;
        out_valid_d       = out_valid_q;
        out_instruction_d = out_instruction_q;
        out_addr_d        = out_addr_q;
        out_err_d         = out_err_q;
        err_code_d        = err_code_q;
        case (state_q)
            IDLE: begin
                if (pc_load) begin
                    addr_d = pc_load_value;
                end else if (in_valid && in_ready) begin
                    fmt_d    = in_fmt;
                    opcode_d = in_opcode;
                    ibit_d   = in_ibit;
                    rd_d     = in_rd;
                    rs1_d    = in_rs1;
                    imm_d    = in_imm;
                    target_d = in_target;
                    state_d  = ENCODE;
                end
            end
            ENCODE: begin
                out_instruction_d = enc_word;
                out_addr_d        = addr_q;
                err_code_d        = enc_code;
                out_err_d         = (enc_code != 2'b00);
                out_valid_d       = 1'b1;
                state_d           = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    addr_d      = addr_q + 32'd4;
                    count_d     = count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            count_q           <= '0;
            fmt_q             <= 1'b0;
            opcode_q          <= '0;
            ibit_q            <= 1'b0;
            rd_q              <= '0;
            rs1_q             <= '0;
            imm_q             <= '0;
            target_q          <= '0;
            out_valid_q       <= 1'b0;
            out_instruction_q <= '0;
            out_addr_q        <= '0;
            out_err_q         <= 1'b0;
            err_code_q        <= '0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            count_q           <= count_d;
            fmt_q             <= fmt_d;
            opcode_q          <= opcode_d;
            ibit_q            <= ibit_d;
            rd_q              <= rd_d;
            rs1_q             <= rs1_d;
            imm_q             <= imm_d;
            target_q          <= target_d;
            out_valid_q       <= out_valid_d;
            out_instruction_q <= out_instruction_d;
            out_addr_q        <= out_addr_d;
            out_err_q         <= out_err_d;
            err_code_q        <= err_code_d;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed scenarios plus randomized requests
// compared against an arithmetic reference model of the encoding rules.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        in_valid;
    logic        in_ready;
    logic        in_fmt;
    logic [4:0]  in_opcode;
    logic        in_ibit;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs1;
    logic [31:0] in_imm;
    logic [31:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_addr;
    logic        out_err;
    logic [1:0]  err_code;
    logic [15:0] count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit [31:0]   m_addr   = 0;
    bit [15:0]   m_count  = 0;
    bit [31:0]   last_word;

    instruction_encoder dut (
        .clk(clk), .reset(reset), .pc_load(pc_load), .pc_load_value(pc_load_value),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_ibit(in_ibit), .in_rd(in_rd), .in_rs1(in_rs1), .in_imm(in_imm),
        .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_addr(out_addr), .out_err(out_err),
        .err_code(err_code), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: encoding expressed as signed integer arithmetic on the field values.
    function automatic void model_encode(input bit fmt, input bit [4:0] op, input bit ibit,
                                         input bit [3:0] rd, input bit [3:0] rs1,
                                         input bit [31:0] imm, input bit [31:0] target,
                                         input bit [31:0] addr,
                                         output bit [31:0] word, output bit [1:0] code);
        longint off, w, field, base, simm;
        code = 2'd0;
        if (fmt) begin
            off = longint'(target) - longint'(addr);
            if (off >= 64'sd2147483648) off -= 64'sd4294967296;
            if (off < -64'sd2147483648) off += 64'sd4294967296;
            w = (off >= 0) ? off / 4 : -((-off + 3) / 4);
            field = w % 134217728;
            if (field < 0) field += 134217728;
            word = 32'(longint'(op) * 134217728 + field);
            if (target % 4 != 0) code = 2'd2;
            else if (w < -67108864 || w > 67108863) code = 2'd3;
        end else begin
            base = longint'(op) * 134217728 + longint'(ibit) * 67108864
                 + longint'(rd) * 4194304 + longint'(rs1) * 262144;
            if (ibit) begin
                simm = longint'($signed(imm));
                word = 32'(base + longint'(imm) % 262144);
                if (simm < -131072 || simm > 131071) code = 2'd1;
            end else begin
                word = 32'(base + (longint'(imm) % 16) * 16384);
            end
        end
    endfunction

    task automatic do_load(input bit [31:0] v);
        @(negedge clk);
        pc_load = 1'b1;
        pc_load_value = v;
        #1 check("in_ready_during_load", in_ready, 0);
        @(negedge clk);
        pc_load = 1'b0;
        m_addr = v;
    endtask

    task automatic send(input bit fmt, input bit [4:0] op, input bit ibit, input bit [3:0] rd,
                        input bit [3:0] rs1, input bit [31:0] imm, input bit [31:0] target,
                        input int unsigned stall);
        bit [31:0] ew, rt;
        bit [1:0]  ec;
        bit [31:0] ea;
        int unsigned waited;
        logic [31:0] hw, ha;
        logic [1:0]  hc;
        model_encode(fmt, op, ibit, rd, rs1, imm, target, m_addr, ew, ec);
        ea = m_addr;
        @(negedge clk);
        in_fmt = fmt; in_opcode = op; in_ibit = ibit; in_rd = rd; in_rs1 = rs1;
        in_imm = imm; in_target = target; in_valid = 1'b1; pc_load = 1'b0;
        #1 check("in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_fmt = 1'($urandom); in_opcode = 5'($urandom); in_imm = $urandom; in_target = $urandom;
        check("out_valid_encode", out_valid, 0);
        waited = 0;
        while (!out_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("out_valid_latency", waited, 1);
        check("out_instruction", out_instruction, ew);
        check("out_addr", out_addr, ea);
        check("err_code", err_code, ec);
        check("out_err", out_err, ec != 0);
        check("count_before", count, m_count);
        if (ec == 0 && fmt) begin
            rt = ({{5{out_instruction[26]}}, out_instruction[26:0]} << 2) + out_addr;
            check("roundtrip_branch", rt, target);
        end else if (ec == 0 && ibit) begin
            check("roundtrip_imm", {{14{out_instruction[17]}}, out_instruction[17:0]}, imm);
        end
        last_word = out_instruction;
        hw = out_instruction; ha = out_addr; hc = err_code;
        for (int unsigned s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid = 1'($urandom);
            pc_load = 1'($urandom);
            pc_load_value = $urandom;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_word", out_instruction, hw);
            check("hold_addr", out_addr, ha);
            check("hold_code", err_code, hc);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        pc_load = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", out_valid, 0);
        check("count_after_hs", count, 16'(m_count + 1));
        m_addr = m_addr + 4;
        m_count = m_count + 1;
    endtask

    bit [31:0]   r_imm, r_tgt;
    bit          r_fmt, r_ibit;
    int unsigned sel;

    initial begin
        reset = 1'b1; pc_load = 1'b0; pc_load_value = '0; in_valid = 1'b1; out_ready = 1'b0;
        in_fmt = 1'b0; in_opcode = '0; in_ibit = 1'b0; in_rd = '0; in_rs1 = '0;
        in_imm = '0; in_target = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instruction", out_instruction, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_err", out_err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_count", count, 0);
        in_valid = 1'b0;
        reset = 1'b0;

        do_load(32'h100);
        send(0, 5'b00000, 1, 4'd3, 4'd2, 32'hFFFFFFFB, 0, 0);
        check("scn1_word", last_word, 32'h04CBFFFB);
        send(1, 5'b10010, 0, 0, 0, 0, 32'h000000F4, 0);
        check("scn2_word", last_word, 32'h97FFFFFC);
        send(1, 5'b00001, 0, 0, 0, 0, 32'h0000010A, 0);
        send(0, 5'b00011, 1, 4'd1, 4'd1, 32'h00020000, 0, 0);
        check("scn4_imm_bits", last_word & 32'h3FFFF, 32'h20000);
        send(0, 5'b00011, 1, 4'd1, 4'd1, 32'hFFFE0000, 0, 5);
        send(0, 5'b00100, 0, 4'd7, 4'd9, 32'h0000000C, 0, 5);

        // pc_load wins over in_valid in IDLE
        @(negedge clk);
        pc_load = 1'b1; pc_load_value = 32'h0000_2000; in_valid = 1'b1;
        #1 check("both_in_ready", in_ready, 0);
        @(negedge clk);
        pc_load = 1'b0; in_valid = 1'b0;
        check("both_no_accept0", out_valid, 0);
        @(negedge clk);
        check("both_no_accept1", out_valid, 0);
        m_addr = 32'h0000_2000;
        send(1, 5'b00101, 0, 0, 0, 0, 32'h0000_1000, 0);

        // reset in HOLD aborts the word
        @(negedge clk);
        in_fmt = 1'b0; in_opcode = 5'd9; in_ibit = 1'b1; in_imm = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_abort_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_word", out_instruction, 0);
        check("abort_addr", out_addr, 0);
        check("abort_err", {31'd0, out_err}, 0);
        check("abort_code", err_code, 0);
        check("abort_count", count, 0);
        check("abort_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        m_addr = 0; m_count = 0;
        send(0, 5'd2, 1, 4'd4, 4'd5, 32'd77, 0, 1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) do_load($urandom & 32'hFFFF_FFFC);
            r_fmt = 1'($urandom);
            r_ibit = 1'($urandom);
            sel = $urandom_range(0, 5);
            case (sel)
                0: r_imm = 32'd131071;
                1: r_imm = 32'd131072;
                2: r_imm = 32'hFFFE0000;
                3: r_imm = 32'hFFFDFFFF;
                4: r_imm = $urandom;
                default: r_imm = 32'($signed($urandom_range(0, 2000)) - 1000);
            endcase
            if ($urandom_range(0, 1) == 0)
                r_tgt = m_addr + (($urandom & 32'h0FFF_FFFF) - 32'h0800_0000);
            else
                r_tgt = $urandom;
            if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
            send(r_fmt, 5'($urandom), r_ibit, 4'($urandom), 4'($urandom), r_imm, r_tgt,
                 $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
